// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants and the fetch FSM state type.
// Holds datapath width, the reset NOP encoding and the sequential PC increment.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage is master; imem answers with a single-cycle ack strobe.
interface inst_fetch_if
    import riscv_pkg::*;
();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry (pc, instruction) holding buffer for a response that lands during a stall.
// Latency: load visible next cycle. Backpressure: none, the owner never loads while full.
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            load_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic [XLEN-1:0] load_data_i,
    output logic            vld_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] data_o
);
    logic            vld_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            pc_q   <= '0;
            data_q <= '0;
        end else if (clear_i) begin
            vld_q <= 1'b0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            pc_q   <= load_pc_i;
            data_q <= load_data_i;
        end else if (pop_i) begin
            vld_q <= 1'b0;
        end
    end

    assign vld_o  = vld_q;
    assign pc_o   = pc_q;
    assign data_o = data_q;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: requests imem at the fetch PC and presents responses to IF_ID.
// Latency 1 cycle ack->ACK_out; stalling freezes outputs, and a stalled response is
// buffered under IFETCH_SKID_BUF_EN or dropped and refetched otherwise.
module inst_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stalling,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    inst_fetch_if.master    imem,
    output logic [XLEN-1:0] PC_out,
    output logic [XLEN-1:0] inst_data_out,
    output logic            ACK_out
);
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            ack_q, ack_d;
    logic            req_en_q;
    logic            ack_vld;

`ifdef IFETCH_SKID_BUF_EN
    logic            buf_load, buf_pop, buf_clear, buf_vld;
    logic [XLEN-1:0] buf_pc, buf_data;

    fetch_skid_buf u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (buf_clear),
        .load_i      (buf_load),
        .pop_i       (buf_pop),
        .load_pc_i   (pc_q),
        .load_data_i (imem.imem_rdata),
        .vld_o       (buf_vld),
        .pc_o        (buf_pc),
        .data_o      (buf_data)
    );
`endif

    // req_en_q keeps imem_req low until the first edge after reset release
    assign imem.imem_req  = req_en_q && (state_q == FETCH);
    assign imem.imem_addr = pc_q;
    assign ack_vld        = imem.imem_ack && imem.imem_req;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        inst_d   = inst_q;
        ack_d    = ack_q;
`ifdef IFETCH_SKID_BUF_EN
        buf_load  = 1'b0;
        buf_pop   = 1'b0;
        buf_clear = 1'b0;
`endif
        if (redirect) begin
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            ack_d   = 1'b0;
            state_d = FETCH;
`ifdef IFETCH_SKID_BUF_EN
            buf_clear = 1'b1;
`endif
        end else if (stalling) begin
            if (ack_vld) begin
                state_d = HOLD;
`ifdef IFETCH_SKID_BUF_EN
                buf_load = 1'b1;
                pc_d     = pc_q + PC_STEP;
`endif
            end
        end else if (state_q == HOLD) begin
            state_d = FETCH;
            ack_d   = 1'b0;
`ifdef IFETCH_SKID_BUF_EN
            if (buf_vld) begin
                pc_out_d = buf_pc;
                inst_d   = buf_data;
                ack_d    = 1'b1;
                buf_pop  = 1'b1;
            end
`endif
        end else if (ack_vld) begin
            pc_out_d = pc_q;
            inst_d   = imem.imem_rdata;
            ack_d    = 1'b1;
            pc_d     = pc_q + PC_STEP;
        end else begin
            ack_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            inst_q   <= NOP_INST;
            ack_q    <= 1'b0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            inst_q   <= inst_d;
            ack_q    <= ack_d;
            req_en_q <= 1'b1;
        end
    end

    assign PC_out        = pc_out_q;
    assign inst_data_out = inst_q;
    assign ACK_out       = ack_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic against a transaction model.
module tb_inst_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
`ifdef IFETCH_SKID_BUF_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stalling, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] PC_out, inst_data_out;
    logic        ACK_out;

    inst_fetch_if imem_if ();

    inst_fetch #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stalling      (stalling),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem          (imem_if),
        .PC_out        (PC_out),
        .inst_data_out (inst_data_out),
        .ACK_out       (ACK_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: next address to fetch, whether the stage is parked after a stalled
    // response, what IF_ID currently sees, and the responses captured during stalls.
    logic [31:0] m_pc, m_pc_out, m_inst;
    bit          m_ack, m_parked, m_live;
    logic [31:0] m_spill_pc[$];
    logic [31:0] m_spill_dat[$];
    logic [31:0] seen_pc[$];
    logic [31:0] acked_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_pc_out = '0; m_inst = NOP_INST;
        m_ack = 0; m_parked = 0; m_live = 0;
        m_spill_pc.delete(); m_spill_dat.delete();
    endtask

    // Called at a falling edge: compare, apply one cycle of inputs, advance the model.
    task automatic step(input bit ack, input bit stall, input bit redir, input logic [31:0] rpc);
        logic [31:0] rdata;
        bit req, got;
        req = m_live && !m_parked;
        check_eq("imem_req", imem_if.imem_req, req);
        check_eq("imem_addr", imem_if.imem_addr, m_pc);
        check_eq("ACK_out", ACK_out, m_ack);
        check_eq("PC_out", PC_out, m_pc_out);
        check_eq("inst_data_out", inst_data_out, m_inst);
        if (ACK_out === 1'b1) begin
            check_eq("data_matches_pc", inst_data_out, PC_out ^ KEY);
            seen_pc.push_back(PC_out);
        end
        rdata = ack ? (m_pc ^ KEY) : $urandom;
        imem_if.imem_ack   = ack;
        imem_if.imem_rdata = rdata;
        stalling    = stall;
        redirect    = redir;
        redirect_pc = rpc;

        got = ack && req;
        if (got && !redir) acked_q.push_back(m_pc);
        if (redir) begin
            m_pc = {rpc[31:2], 2'b00};
            m_ack = 0; m_parked = 0;
            m_spill_pc.delete(); m_spill_dat.delete();
        end else if (stall) begin
            if (got) begin
                m_parked = 1;
                if (SKID) begin
                    m_spill_pc.push_back(m_pc);
                    m_spill_dat.push_back(rdata);
                    m_pc = m_pc + 32'd4;
                end
            end
        end else if (m_parked) begin
            m_parked = 0;
            m_ack = 0;
            if (m_spill_pc.size() > 0) begin
                m_pc_out = m_spill_pc.pop_front();
                m_inst   = m_spill_dat.pop_front();
                m_ack    = 1;
            end
        end else if (got) begin
            m_pc_out = m_pc; m_inst = rdata; m_ack = 1;
            m_pc = m_pc + 32'd4;
        end else begin
            m_ack = 0;
        end
        m_live = 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_ack"},  ACK_out, 1'b0);
        check_eq({pfx, "_inst"}, inst_data_out, NOP_INST);
        check_eq({pfx, "_pcout"}, PC_out, 32'h0);
        check_eq({pfx, "_req"},  imem_if.imem_req, 1'b0);
        check_eq({pfx, "_addr"}, imem_if.imem_addr, RST_PC);
    endtask

    // Entered at a falling edge; reset lands mid-cycle with a concurrent ack.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        imem_if.imem_ack = 1'b1;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        imem_if.imem_ack = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; stalling = 0; redirect = 0; redirect_pc = '0;
        imem_if.imem_ack = 0; imem_if.imem_rdata = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Back-to-back acks from reset: 0,4,8 on consecutive cycles
        seen_pc.delete();
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        check_eq("stream_len", seen_pc.size() >= 3, 1'b1);
        if (seen_pc.size() >= 3) begin
            check_eq("stream_pc0", seen_pc[0], 32'h0);
            check_eq("stream_pc1", seen_pc[1], 32'h4);
            check_eq("stream_pc2", seen_pc[2], 32'h8);
        end

        // Slow memory at 0x10: three idle cycles then the ack
        step(0, 0, 1, 32'h10);
        for (int i = 0; i < 3; i++) begin
            check_eq("slow_addr", imem_if.imem_addr, 32'h10);
            step(0, 0, 0, 0);
        end
        step(1, 0, 0, 0);
        check_eq("slow_ack", ACK_out, 1'b1);
        check_eq("slow_pc", PC_out, 32'h10);

        // Response to 0x20 lands while stalled
        step(0, 0, 1, 32'h20);
        acked_q.delete(); seen_pc.delete();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        cnt = 0;
        foreach (acked_q[i]) if (acked_q[i] == 32'h20) cnt++;
        check_eq("stall_fetches_0x20", cnt, SKID ? 1 : 2);
        check_eq("stall_first_pc", seen_pc.size() > 0 ? seen_pc[0] : 32'hDEAD_BEEF, 32'h20);

        // Redirect colliding with the ack for 0x40
        step(0, 0, 1, 32'h40);
        seen_pc.delete();
        step(1, 0, 1, 32'h103);
        check_eq("redir_ack", ACK_out, 1'b0);
        check_eq("redir_addr", imem_if.imem_addr, 32'h100);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        cnt = 0;
        foreach (seen_pc[i]) if (seen_pc[i] == 32'h40) cnt++;
        check_eq("redir_0x40_seen", cnt, 0);

        // PC wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFF8);
        acked_q.delete();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        check_eq("wrap_len", acked_q.size(), 3);
        if (acked_q.size() == 3) begin
            check_eq("wrap_a0", acked_q[0], 32'hFFFF_FFF8);
            check_eq("wrap_a1", acked_q[1], 32'hFFFF_FFFC);
            check_eq("wrap_a2", acked_q[2], 32'h0000_0000);
        end

        // Reset pulse while a request is outstanding
        step(0, 0, 1, 32'h80);
        step(0, 0, 0, 0);
        pulse_reset();
        step(0, 0, 0, 0);
        check_eq("restart_req", imem_if.imem_req, 1'b1);
        check_eq("restart_addr", imem_if.imem_addr, RST_PC);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) pulse_reset();
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
